// File: rtl/dump_stream_framer.sv
// Trade-log dump framer: on start_dump, reads the word buffer and streams
// HDR, 16-bit count, words MSB-first and a tlast-flagged sentinel over AXI-Stream.
module dump_stream_framer #(
  parameter int         WORD_WIDTH    = 64,
  parameter int         ADDR_WIDTH    = 8,
  parameter logic [7:0] HDR_BYTE      = 8'hAA,
  parameter logic [7:0] SENTINEL_BYTE = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_dump,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [WORD_WIDTH-1:0] rd_data,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done
);

  localparam int NB = WORD_WIDTH / 8;
  localparam int BW = $clog2(NB) + 1;
  localparam logic [BW-1:0] LAST_B = BW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_CNT_HI, S_CNT_LO, S_FETCH, S_LOAD, S_BYTES, S_SENT
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  // Index of the next word to fetch; one bit wider so a full buffer needs no wrap.
  logic [ADDR_WIDTH:0]     widx_q, widx_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [WORD_WIDTH-1:0]   shift_q, shift_d;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  logic                    done_q, done_d;
  logic [15:0]             cnt16;
  logic                    hs;

  assign cnt16 = 16'(count_q);
  assign hs    = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      widx_q    <= '0;
      rd_addr_q <= '0;
      shift_q   <= '0;
      bcnt_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      widx_q    <= widx_d;
      rd_addr_q <= rd_addr_d;
      shift_q   <= shift_d;
      bcnt_q    <= bcnt_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    widx_d    = widx_q;
    rd_addr_d = rd_addr_q;
    shift_d   = shift_q;
    bcnt_d    = bcnt_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: if (start_dump) begin
        state_d = S_HDR;
        count_d = word_count;
        widx_d  = '0;
      end
      S_HDR:    if (hs) state_d = S_CNT_HI;
      S_CNT_HI: if (hs) state_d = S_CNT_LO;
      S_CNT_LO: if (hs) begin
        if (count_q != '0) begin
          state_d   = S_FETCH;
          rd_addr_d = widx_q[ADDR_WIDTH-1:0];
        end else begin
          state_d = S_SENT;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
        widx_d  = widx_q + (ADDR_WIDTH+1)'(1);
      end
      S_LOAD: begin
        shift_d = rd_data;
        bcnt_d  = '0;
        state_d = S_BYTES;
      end
      S_BYTES: if (hs) begin
        shift_d = shift_q << 8;
        bcnt_d  = bcnt_q + BW'(1);
        if (bcnt_q == LAST_B) begin
          if (widx_q < count_q) begin
            state_d   = S_FETCH;
            rd_addr_d = widx_q[ADDR_WIDTH-1:0];
          end else begin
            state_d = S_SENT;
          end
        end
      end
      S_SENT: if (hs) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stream outputs decode straight from state so reset clears them immediately.
  always_comb begin
    m_axis_tdata = 8'h00;
    case (state_q)
      S_HDR:    m_axis_tdata = HDR_BYTE;
      S_CNT_HI: m_axis_tdata = cnt16[15:8];
      S_CNT_LO: m_axis_tdata = cnt16[7:0];
      S_BYTES:  m_axis_tdata = shift_q[WORD_WIDTH-1 -: 8];
      S_SENT:   m_axis_tdata = SENTINEL_BYTE;
      default:  m_axis_tdata = 8'h00;
    endcase
  end

  assign m_axis_tvalid = (state_q == S_HDR) || (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                         (state_q == S_BYTES) || (state_q == S_SENT);
  assign m_axis_tlast  = (state_q == S_SENT);
  assign rd_en         = (state_q == S_FETCH);
  assign rd_addr       = rd_addr_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_dump_stream_framer.sv
// Self-checking bench for dump_stream_framer: random buffers and backpressure
// compared against a byte-queue model of the frame format.
module tb_dump_stream_framer;
  localparam int WW = 64;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_dump = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [WW-1:0] rd_data = '0;
  logic [7:0]    tdata;
  logic          tvalid, tlast;
  logic          tready = 1'b1;
  logic          busy, done;

  dump_stream_framer #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_dump(start_dump), .word_count(word_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
    .m_axis_tready(tready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor state
  bit            mon_on = 1'b0;
  bit            rnd_ready = 1'b0;
  logic [8:0]    cap_q[$];
  logic [AW-1:0] addr_q[$];
  int            busy_cyc;
  bit            prev_stall, prev_last_hs;
  logic [7:0]    prev_data;
  logic [AW-1:0] last_addr = '0;

  initial forever begin
    @(posedge clk); #1;
    tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) if (mon_on) begin
    if (prev_stall) begin
      chk("hold_valid", 64'(tvalid), 64'd1);
      chk("hold_data", 64'(tdata), 64'(prev_data));
    end
    chk("done_pulse", 64'(done), 64'(prev_last_hs));
    if (prev_last_hs) chk("busy_fall", 64'(busy), 64'd0);
    if (busy) busy_cyc++;
    if (rd_en) begin
      addr_q.push_back(rd_addr);
      last_addr = rd_addr;
    end else begin
      chk("rd_addr_hold", 64'(rd_addr), 64'(last_addr));
    end
    if (tvalid && tready) cap_q.push_back({tlast, tdata});
    prev_stall   = tvalid && !tready;
    prev_data    = tdata;
    prev_last_hs = tvalid && tready && tlast;
  end

  // Reference frame: header, 16-bit count, words MSB byte first, sentinel.
  task automatic build_exp(input int cnt, output logic [8:0] e[$]);
    logic [WW-1:0] w;
    e.delete();
    e.push_back({1'b0, 8'hAA});
    e.push_back({1'b0, 8'(cnt / 256)});
    e.push_back({1'b0, 8'(cnt % 256)});
    for (int k = 0; k < cnt; k++) begin
      w = mem[k];
      for (int b = WW/8 - 1; b >= 0; b--) e.push_back({1'b0, 8'(w >> (8*b))});
    end
    e.push_back({1'b1, 8'h55});
  endtask

  task automatic run_frame(input string tag, input int cnt, input bit rnd, input int inject_at);
    logic [8:0] e[$];
    bit finished = 1'b0;
    int n;
    build_exp(cnt, e);
    cap_q.delete(); addr_q.delete();
    busy_cyc = 0; prev_stall = 0; prev_last_hs = 0;
    rnd_ready = rnd;
    @(posedge clk); #1;
    word_count = (AW+1)'(cnt);
    start_dump = 1'b1;
    mon_on = 1'b1;
    @(posedge clk); #1;
    start_dump = 1'b0;
    chk({tag, "_first_valid"}, 64'(tvalid), 64'd1);
    chk({tag, "_first_busy"}, 64'(busy), 64'd1);
    chk({tag, "_first_hdr"}, 64'(tdata), 64'hAA);
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (i == inject_at) begin
        start_dump = 1'b1;
        word_count = (AW+1)'(5);
      end else if (i == inject_at + 1) begin
        start_dump = 1'b0;
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
    end
    start_dump = 1'b0;
    chk({tag, "_finished"}, 64'(finished), 64'd1);
    @(negedge clk); #1;
    mon_on = 1'b0;
    rnd_ready = 1'b0;
    chk({tag, "_len"}, 64'(cap_q.size()), 64'(e.size()));
    n = (cap_q.size() < e.size()) ? cap_q.size() : e.size();
    for (int k = 0; k < n; k++) chk({tag, "_byte"}, 64'(cap_q[k]), 64'(e[k]));
    chk({tag, "_rd_cnt"}, 64'(addr_q.size()), 64'(cnt));
    for (int k = 0; k < addr_q.size() && k < cnt; k++)
      chk({tag, "_rd_addr"}, 64'(addr_q[k]), 64'(k));
    if (!rnd) chk({tag, "_cycles"}, 64'(busy_cyc), 64'(4 + cnt * (2 + WW/8)));
  endtask

  initial begin
    for (int k = 0; k < (1<<AW); k++) mem[k] = {$urandom, $urandom};
    #2;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outs", 64'({tlast, tdata, rd_en, rd_addr, done}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    mem[0] = 64'h0102030405060708;
    mem[1] = 64'h1112131415161718;
    run_frame("two", 2, 1'b0, -10);
    run_frame("zero", 0, 1'b0, -10);
    run_frame("two_bp", 2, 1'b1, -10);
    run_frame("inject", 2, 1'b0, 16);
    run_frame("full", 256, 1'b0, -10);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++) mem[k] = {$urandom, $urandom};
      run_frame("rand", $urandom_range(0, 7), 1'($urandom_range(0, 1)), -10);
    end

    // Reset while streaming word 0 bytes
    @(posedge clk); #1;
    word_count = (AW+1)'(2);
    start_dump = 1'b1;
    @(posedge clk); #1;
    start_dump = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); #2;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_outs", 64'({tlast, tdata, rd_en, rd_addr, done}), 64'd0);
    last_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem[0] = {$urandom, $urandom};
    run_frame("post_rst", 1, 1'b0, -10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
